// File: rtl/clk_meter_pkg.sv
// Shared types and defaults for the clock period meter.
// Holds the control FSM state type and the default counter width and timeout.
package clk_meter_pkg;

  localparam int unsigned DefaultW       = 32;
  localparam int unsigned DefaultTimeout = 100_000_000;

  typedef enum logic [1:0] {
    StIdle,
    StMeasure,
    StStall
  } meter_state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for sig_in plus a history flop.
// Flags a transition of either polarity on the synchronized signal.
module sync_edge_det (
  input  logic clk_in,
  input  logic rst,
  input  logic sig_in,
  output logic sig_edge,
  output logic prev_level
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= sig_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign sig_edge   = s2_q ^ s3_q;
  assign prev_level = s3_q;

endmodule

// File: rtl/clk_period_meter.sv
// Measures the clk_in-cycle length of each sig_in half period.
// Reports the divider setting that regenerates it, and flags lock and timeout.
module clk_period_meter
  import clk_meter_pkg::*;
#(
  parameter int unsigned W       = DefaultW,
  parameter int unsigned TIMEOUT = DefaultTimeout
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic         sig_in,
  output logic [W-1:0] half_period,
  output logic [W-1:0] div_n,
  output logic         level,
  output logic         valid,
  output logic         locked,
  output logic         timeout
);

  localparam logic [W-1:0] TimeoutLast = W'(TIMEOUT - 1);

  logic         sig_edge;
  logic         prev_level;

  meter_state_e state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] half_period_q, half_period_d;
  logic [W-1:0] div_n_q, div_n_d;
  logic         level_q, level_d;
  logic         valid_q, valid_d;
  logic         locked_q, locked_d;
  logic         timeout_q, timeout_d;
  // A measurement exists to compare against since the last IDLE/STALL.
  logic         have_prev_q, have_prev_d;
  logic [W-1:0] cnt_plus1;

  sync_edge_det u_sync_edge_det (
    .clk_in     (clk_in),
    .rst        (rst),
    .sig_in     (sig_in),
    .sig_edge   (sig_edge),
    .prev_level (prev_level)
  );

  assign cnt_plus1 = cnt_q + W'(1);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    half_period_d = half_period_q;
    div_n_d       = div_n_q;
    level_d       = level_q;
    valid_d       = 1'b0;
    locked_d      = locked_q;
    timeout_d     = timeout_q;
    have_prev_d   = have_prev_q;

    unique case (state_q)
      StIdle: begin
        if (sig_edge) begin
          state_d = StMeasure;
          cnt_d   = '0;
        end
      end
      StMeasure: begin
        if (sig_edge) begin
          half_period_d = cnt_plus1;
          div_n_d       = cnt_q;
          level_d       = prev_level;
          valid_d       = 1'b1;
          locked_d      = have_prev_q && (cnt_plus1 == half_period_q);
          have_prev_d   = 1'b1;
          cnt_d         = '0;
        end else if (cnt_q == TimeoutLast) begin
          // Edge in this same cycle would have taken the branch above.
          state_d     = StStall;
          timeout_d   = 1'b1;
          locked_d    = 1'b0;
          have_prev_d = 1'b0;
        end else begin
          cnt_d = cnt_plus1;
        end
      end
      StStall: begin
        if (sig_edge) begin
          state_d   = StMeasure;
          cnt_d     = '0;
          timeout_d = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      half_period_q <= '0;
      div_n_q       <= '0;
      level_q       <= 1'b0;
      valid_q       <= 1'b0;
      locked_q      <= 1'b0;
      timeout_q     <= 1'b0;
      have_prev_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      half_period_q <= half_period_d;
      div_n_q       <= div_n_d;
      level_q       <= level_d;
      valid_q       <= valid_d;
      locked_q      <= locked_d;
      timeout_q     <= timeout_d;
      have_prev_q   <= have_prev_d;
    end
  end

  assign half_period = half_period_q;
  assign div_n       = div_n_q;
  assign level       = level_q;
  assign valid       = valid_q;
  assign locked      = locked_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter with TIMEOUT=20.
// Valid pulses are logged by a monitor and compared against hand-computed records.
module tb_clk_period_meter;

  localparam int unsigned W       = 32;
  localparam int unsigned TIMEOUT = 20;

  logic         clk_in = 1'b0;
  logic         rst    = 1'b1;
  logic         sig_in = 1'b0;
  logic [W-1:0] half_period;
  logic [W-1:0] div_n;
  logic         level;
  logic         valid;
  logic         locked;
  logic         timeout;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] hp;
    logic [31:0] dn;
    logic        lvl;
    logic        lk;
    logic        to;
  } vrec_t;

  vrec_t vq[$];

  always #5 clk_in = ~clk_in;

  clk_period_meter #(
    .W       (W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .sig_in      (sig_in),
    .half_period (half_period),
    .div_n       (div_n),
    .level       (level),
    .valid       (valid),
    .locked      (locked),
    .timeout     (timeout)
  );

  always @(negedge clk_in) begin
    if (valid) vq.push_back('{hp: half_period, dn: div_n, lvl: level, lk: locked, to: timeout});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic expect_valid(input string tag, input int hp, input logic lvl, input logic lk);
    vrec_t r;
    if (vq.size() == 0) begin
      check({tag, "_present"}, 32'(vq.size()), 1);
    end else begin
      r = vq.pop_front();
      check({tag, "_hp"}, r.hp, hp);
      check({tag, "_div_n"}, r.dn, hp - 1);
      check({tag, "_level"}, 32'(r.lvl), 32'(lvl));
      check({tag, "_locked"}, 32'(r.lk), 32'(lk));
      check({tag, "_timeout"}, 32'(r.to), 0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_hp"}, half_period, 0);
    check({tag, "_div_n"}, div_n, 0);
    check({tag, "_level"}, 32'(level), 0);
    check({tag, "_valid"}, 32'(valid), 0);
    check({tag, "_locked"}, 32'(locked), 0);
    check({tag, "_timeout"}, 32'(timeout), 0);
  endtask

  // Toggle sig_in n clocks from now, so consecutive calls set the half period.
  task automatic toggle_after(input int n);
    repeat (n) @(posedge clk_in);
    #1 sig_in = ~sig_in;
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk_in);
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state.
    wait_clks(3);
    @(negedge clk_in);
    check_all_zero("reset");
    @(posedge clk_in);
    #1 rst = 1'b0;

    // Divider n=4: five toggles, the first only leaves IDLE.
    for (int i = 0; i < 5; i++) toggle_after(5);

    // Timeout lands 20 cycles after the last edge is registered.
    wait_clks(22);
    @(negedge clk_in);
    check("pre_timeout", 32'(timeout), 0);
    check("pre_timeout_locked", 32'(locked), 1);
    @(posedge clk_in);
    @(negedge clk_in);
    check("timeout_set", 32'(timeout), 1);
    check("timeout_locked", 32'(locked), 0);
    wait_clks(5);
    @(negedge clk_in);
    check("stall_hp_kept", half_period, 5);
    check("stall_level_kept", 32'(level), 0);
    check("n4_count", 32'(vq.size()), 4);
    expect_valid("n4_v1", 5, 1'b1, 1'b0);
    expect_valid("n4_v2", 5, 1'b0, 1'b1);
    expect_valid("n4_v3", 5, 1'b1, 1'b1);
    expect_valid("n4_v4", 5, 1'b0, 1'b1);

    // Edge out of STALL clears timeout without a valid.
    toggle_after(1);
    wait_clks(4);
    @(negedge clk_in);
    check("stall_exit_timeout", 32'(timeout), 0);
    check("stall_exit_no_valid", 32'(vq.size()), 0);
    toggle_after(1);
    toggle_after(5);
    // Divider switches to n=9, then a one-cycle low glitch on a high level.
    toggle_after(10);
    toggle_after(10);
    toggle_after(10);
    toggle_after(7);
    toggle_after(1);
    toggle_after(8);
    wait_clks(4);
    check("run2_count", 32'(vq.size()), 8);
    expect_valid("resume_v1", 5, 1'b0, 1'b0);
    expect_valid("resume_v2", 5, 1'b1, 1'b1);
    expect_valid("n9_v1", 10, 1'b0, 1'b0);
    expect_valid("n9_v2", 10, 1'b1, 1'b1);
    expect_valid("n9_v3", 10, 1'b0, 1'b1);
    expect_valid("glitch_pre", 7, 1'b1, 1'b0);
    expect_valid("glitch_low", 1, 1'b0, 1'b0);
    expect_valid("glitch_rest", 8, 1'b1, 1'b0);

    // One-cycle reset in the middle of an n=4 run.
    toggle_after(5);
    toggle_after(5);
    toggle_after(5);
    wait_clks(3);
    #1 rst = 1'b1;
    @(posedge clk_in);
    #1 rst = 1'b0;
    @(negedge clk_in);
    check_all_zero("midreset");
    check("prereset_count", 32'(vq.size()), 3);
    expect_valid("prereset_v1", 9, 1'b0, 1'b0);
    expect_valid("prereset_v2", 5, 1'b1, 1'b0);
    expect_valid("prereset_v3", 5, 1'b0, 1'b1);
    // sig_in=1 through reset registers as the first post-reset edge.
    toggle_after(5);
    toggle_after(5);
    wait_clks(4);
    check("postreset_count", 32'(vq.size()), 2);
    expect_valid("postreset_v1", 5, 1'b1, 1'b0);
    expect_valid("postreset_v2", 5, 1'b0, 1'b1);

    // Edge on the same cycle cnt hits TIMEOUT-1 wins over the timeout.
    toggle_after(16);
    wait_clks(3);
    @(negedge clk_in);
    check("edge_at_limit_valid", 32'(valid), 1);
    check("edge_at_limit_hp", half_period, TIMEOUT);
    check("edge_at_limit_timeout", 32'(timeout), 0);
    @(negedge clk_in);
    check("valid_one_cycle", 32'(valid), 0);
    check("edge_at_limit_count", 32'(vq.size()), 1);
    expect_valid("edge_at_limit", TIMEOUT, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_period_meter.md
CLK_PERIOD_METER -- requirements
Module: clk_period_meter

Interface
REQ-001 Parameter W, default 32: width of every counter and measurement output.
REQ-002 Parameter TIMEOUT, default 100_000_000: clk_in cycles without a sig_in edge before timeout; SHALL be in the range 2..2^W-2.
REQ-003 clk_in  input  1  sole clock; all logic is on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 sig_in  input  1  asynchronous slow clock or level under measurement, e.g. the output of the team's divider.
REQ-006 half_period  output  W  clk_in cycles between the last two accepted sig_in edges.
REQ-007 div_n  output  W  half_period-1; equals the divider parameter n that regenerates sig_in.
REQ-008 level  output  1  sig_in level that ended at the last accepted edge (1 = high phase measured).
REQ-009 valid  output  1  one-cycle pulse when half_period, div_n and level update.
REQ-010 locked  output  1  last two measurements were equal.
REQ-011 timeout  output  1  sticky flag: no edge seen for TIMEOUT cycles.

Function
REQ-012 sig_in SHALL pass through a two-flop synchronizer (s1, s2); a third flop s3 holds the previous s2 value.
REQ-013 An edge SHALL be detected in any cycle where s2 != s3, for both polarities.
REQ-014 The control FSM SHALL have three states: IDLE, MEASURE and STALL.
REQ-015 IDLE: entered on reset; cnt is held at 0; the first edge moves to MEASURE with cnt<=0; no valid is produced.
REQ-016 MEASURE, non-edge cycle: cnt<=cnt+1.
REQ-017 MEASURE, edge cycle: the module SHALL register half_period<=cnt+1, div_n<=cnt and level<=s3, pulse valid for one cycle, and set cnt<=0.
REQ-018 MEASURE: when cnt reaches TIMEOUT-1 in a non-edge cycle, the FSM SHALL go to STALL with timeout<=1 and locked<=0; an edge in that same cycle takes precedence, and no timeout occurs.
REQ-019 STALL: cnt is held; half_period, div_n and level are retained; an edge SHALL move the FSM to MEASURE with cnt<=0, timeout<=0 and no valid pulse.
REQ-020 Latency: a sig_in transition first sampled at clk_in edge T0 SHALL produce valid high during the cycle after edge T2.
REQ-021 locked SHALL be set on a valid whose half_period equals the previous valid's value since the last IDLE/STALL, and cleared on a valid with an unequal value.
REQ-022 The minimum measurable half period is 1 cycle, for an edge on consecutive cycles; there is no saturation because timeout bounds cnt.
REQ-023 All outputs SHALL be registered; no output is driven combinationally from sig_in.

Reset
REQ-024 While rst=1: s1, s2 and s3 SHALL be 0, the FSM SHALL be in IDLE, and cnt, half_period, div_n, level, valid, locked and timeout SHALL all be 0.
REQ-025 rst SHALL win over every simultaneous event, including an edge or a timeout; a reset mid-measurement discards the partial count.
REQ-026 After release, sig_in=1 SHALL register as a rising edge once s2 updates: the FSM leaves IDLE and no valid is produced.

Structure
REQ-027 Package clk_meter_pkg SHALL hold the FSM state enum (IDLE, MEASURE, STALL) and the default W and TIMEOUT constants.
REQ-028 Sub-module sync_edge_det SHALL contain the synchronizer, the s3 flop and the edge output; it SHALL reset synchronously on rst.

Verification
REQ-029 Divider model with n=4 (sig_in toggles every 5 cycles) -> first valid after the second edge with half_period=5, div_n=4, level alternating; locked=1 from the second valid.
REQ-030 With TIMEOUT=20, hold sig_in constant after lock -> timeout=1 and locked=0 exactly 20 cycles after the last edge detection; next edge -> timeout=0 and no valid; following edge -> valid.
REQ-031 Switch the model from n=4 to n=9 -> first mismatching valid shows half_period=10 and clears locked; next valid (10) sets locked.
REQ-032 Single-cycle glitch on an otherwise-high sig_in -> two consecutive valids: half_period=1 (level=0), then the remaining count (level=1); locked=0.
REQ-033 Assert rst for one cycle mid-half-period in the n=4 run -> all outputs 0 next cycle; first post-reset valid only after two new edges, with value 5.
REQ-034 Edge arriving in the same cycle cnt reaches TIMEOUT-1 -> valid with half_period=TIMEOUT and no timeout.
